sram_arbiter: RTL and testbench
===============================

// Module: sram_arbiter
// PURPOSE
//  Shares the single external SRAM port (via the SRAM controller) among NUM_REQ on-chip masters.
//  Masters are the UART loader, the M1 upsample/CSC, the M2 IDCT fetch/write and the VGA reader.
//  Sits between those masters and the SRAM controller; owns top-level SRAM sequencing.
//  Issues at most one access per cycle; read data returns tagged to the issuing master.
// PARAMETERS
//  NUM_REQ       4   number of requesting masters (index 0 = highest fixed priority)
//  MAX_BURST     32  max consecutive accesses per grant when another master is waiting
//  READ_LATENCY  2   cycles from SRAM_address_o change to SRAM_read_data_i valid
// PORTS
//  Clock_50          in   1            system clock; all state on posedge
//  Resetn            in   1            asynchronous, active-low reset
//  Req_i             in   NUM_REQ      per-master request; held high for a burst
//  Addr_i            in   NUM_REQ x18  per-master word address
//  Wdata_i           in   NUM_REQ x16  per-master write data
//  We_n_i            in   NUM_REQ      per-master write enable, active-low
//  Grant_o           out  NUM_REQ      one-hot registered grant
//  Rdata_o           out  16           shared read-data bus
//  Rvalid_o          out  NUM_REQ      one-hot pulse: Rdata_o belongs to that master
//  SRAM_address_o    out  18           to SRAM controller
//  SRAM_write_data_o out  16           to SRAM controller
//  SRAM_we_n_o       out  1            to SRAM controller, active-low
//  SRAM_read_data_i  in   16           from SRAM controller
// BEHAVIOUR
//  - Reset: Grant_o=0, Rvalid_o=0, Rdata_o=0, SRAM_address_o=0, SRAM_write_data_o=0, SRAM_we_n_o=1.
//    Burst counter=0, RR pointer=0, FSM=S_ARB_IDLE.
//  - FSM S_ARB_IDLE: if |Req_i, pick winner w, set Grant_o[w] at next edge, go to S_ARB_OWN. Else stay.
//  - FSM S_ARB_OWN, access cycle (Grant_o[g] & Req_i[g]):
//    register Addr_i[g], Wdata_i[g] and We_n_i[g] onto the SRAM_* outputs at the next edge.
//    Increment the burst counter.
//  - Idle SRAM cycles (no access issued): SRAM_we_n_o=1; address and write data hold their last values.
//  - Release on Req_i[g]=0: that cycle issues nothing; Grant_o clears at the next edge; go to S_ARB_IDLE.
//  - Release on MAX_BURST: when the access at count MAX_BURST-1 issues and another Req_i bit is high,
//    Grant_o clears at the next edge. Otherwise the counter saturates and the grant is kept.
//  - Every grant change passes through one S_ARB_IDLE cycle, so there is 1 dead cycle per handover.
//  - Latency: Req_i rise (idle arbiter) -> Grant_o at +1 -> SRAM_address_o at +2 -> Rvalid_o/Rdata_o at
//    +2+READ_LATENCY. In a burst, one read per cycle returns in issue order.
//  - Read tag pipeline: READ_LATENCY+1 deep. Carries the one-hot owner of each read (reads only).
//    Writes produce no Rvalid_o. Rdata_o is registered from SRAM_read_data_i.
//  - Simultaneous requests: winner chosen by the pick policy (CONFIGURATION).
//  - Req_i bits of non-granted masters are ignored. Addr_i/We_n_i of non-granted masters are don't-care.
//  - Write-then-read to the same address: strictly ordered; the read returns the new data.
//  - Reset mid-burst: all state clears asynchronously; in-flight reads are dropped (no Rvalid_o).
// CONFIGURATION
//  SRAM_ARB_ROUND_ROBIN_EN defined: round-robin pick. Search starts at (last granted index + 1) mod
//    NUM_REQ; the RR pointer updates on each grant.
//  Undefined: fixed priority, lowest index wins. The RR pointer logic is absent.
// STRUCTURE
//  sram_arb_pkg: SRAM_ADDR_W=18, SRAM_DATA_W=16, typedef enum {S_ARB_IDLE, S_ARB_OWN} arb_state_type.
//  Sub-module sram_arb_pick: combinational winner select (req vector, rr pointer -> one-hot).
//  Top holds the FSM, burst counter, SRAM output registers and the read tag pipeline.
// TESTING
//  1 Reset: Resetn=0 mid-burst of 5 reads by master 1 -> outputs at reset values;
//    no Rvalid_o for the in-flight reads.
//  2 Single read: Req_i=4'b0100, Addr_i[2]=18'h0_1234, SRAM holds 16'hBEEF there ->
//    Grant_o=0100 at +1; Rvalid_o=0100 with Rdata_o=16'hBEEF at +4.
//  3 Burst: master 0 holds 8 reads at 0..7 -> Rvalid_o[0] pulses for 8 consecutive cycles,
//    data in address order.
//  4 Contention: Req_i=4'b1001 held, MAX_BURST=4 -> fixed: master 0 owns indefinitely
//    (no other pending after mask); RR: alternating 4-access grants to 0 and 3 with 1 idle cycle each.
//  5 Write/read: master 2 writes 16'hA5A5 to 18'h3FFFF, then reads it back ->
//    Rdata_o=16'hA5A5, and SRAM_we_n_o is low for exactly 1 cycle.
//  6 Early release: master 3 drops Req_i after 2 of 6 accesses while master 1 waits ->
//    Grant_o[3] clears next edge; Grant_o[1] is asserted 2 cycles after the drop.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared widths, FSM encoding and helpers for the SRAM arbiter slice.
package sram_arb_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;

    typedef enum logic {
        S_ARB_IDLE,
        S_ARB_OWN
    } arb_state_type;

    // Width of an index into NUM_REQ masters; never narrower than one bit.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational winner select: first requester found searching upward from ptr_i (wrapping).
module sram_arb_pick
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = ptr_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] win_o
);

    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        win_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = PTR_W'((int'(ptr_i) + i) % NUM_REQ);
            if (!found && req_i[idx]) begin
                win_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one SRAM controller port among NUM_REQ masters; read data is tagged back to its issuer.
// Define SRAM_ARB_ROUND_ROBIN_EN for round-robin pick; default build uses fixed priority (index 0 wins).
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int MAX_BURST    = 32,
    parameter int READ_LATENCY = 2
) (
    input  logic                                  Clock_50,
    input  logic                                  Resetn,
    input  logic [NUM_REQ-1:0]                    Req_i,
    input  logic [NUM_REQ-1:0][SRAM_ADDR_W-1:0]   Addr_i,
    input  logic [NUM_REQ-1:0][SRAM_DATA_W-1:0]   Wdata_i,
    input  logic [NUM_REQ-1:0]                    We_n_i,
    output logic [NUM_REQ-1:0]                    Grant_o,
    output logic [SRAM_DATA_W-1:0]                Rdata_o,
    output logic [NUM_REQ-1:0]                    Rvalid_o,
    output logic [SRAM_ADDR_W-1:0]                SRAM_address_o,
    output logic [SRAM_DATA_W-1:0]                SRAM_write_data_o,
    output logic                                  SRAM_we_n_o,
    input  logic [SRAM_DATA_W-1:0]                SRAM_read_data_i
);

    localparam int PTR_W = ptr_w(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

    arb_state_type                  state_q, state_d;
    logic [NUM_REQ-1:0]             grant_q, grant_d;
    logic [CNT_W-1:0]               burst_q, burst_d;
    logic [NUM_REQ-1:0]             win, others, tag_in;
    logic [PTR_W-1:0]               rr_ptr;
    logic                           issue;
    logic [SRAM_ADDR_W-1:0]         sel_addr;
    logic [SRAM_DATA_W-1:0]         sel_wdata;
    logic                           sel_we_n;
    logic [READ_LATENCY:0][NUM_REQ-1:0] tag_q;

    sram_arb_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req_i (Req_i),
        .ptr_i (rr_ptr),
        .win_o (win)
    );

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic [PTR_W-1:0] rr_q, rr_d;

    always_comb begin
        rr_d = rr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win[i]) rr_d = PTR_W'((i + 1) % NUM_REQ);
        end
    end

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn)                            rr_q <= '0;
        else if (state_q == S_ARB_IDLE && |Req_i) rr_q <= rr_d;
    end

    assign rr_ptr = rr_q;
    assign others = Req_i & ~grant_q;
`else
    assign rr_ptr = '0;
    // Only higher-priority (lower-index) requesters can force a burst release.
    assign others = Req_i & (grant_q - NUM_REQ'(1));
`endif

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we_n  = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                sel_addr  = Addr_i[i];
                sel_wdata = Wdata_i[i];
                sel_we_n  = We_n_i[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        burst_d = burst_q;
        issue   = 1'b0;
        case (state_q)
            S_ARB_IDLE: begin
                if (|Req_i) begin
                    grant_d = win;
                    burst_d = '0;
                    state_d = S_ARB_OWN;
                end
            end
            S_ARB_OWN: begin
                if (|(grant_q & Req_i)) begin
                    issue = 1'b1;
                    if (burst_q != BURST_LAST) begin
                        burst_d = burst_q + CNT_W'(1);
                    end else if (|others) begin
                        grant_d = '0;
                        state_d = S_ARB_IDLE;
                    end
                end else begin
                    grant_d = '0;
                    state_d = S_ARB_IDLE;
                end
            end
            default: state_d = S_ARB_IDLE;
        endcase
    end

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_ARB_IDLE;
            grant_q <= '0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            burst_q <= burst_d;
        end
    end

    // Only reads carry a tag; writes push an empty slot so returns stay aligned.
    assign tag_in = (issue && sel_we_n) ? grant_q : '0;

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            SRAM_address_o    <= '0;
            SRAM_write_data_o <= '0;
            SRAM_we_n_o       <= 1'b1;
            tag_q             <= '0;
            Rdata_o           <= '0;
        end else begin
            if (issue) begin
                SRAM_address_o    <= sel_addr;
                SRAM_write_data_o <= sel_wdata;
                SRAM_we_n_o       <= sel_we_n;
            end else begin
                SRAM_we_n_o       <= 1'b1;
            end
            tag_q   <= {tag_q[READ_LATENCY-1:0], tag_in};
            Rdata_o <= SRAM_read_data_i;
        end
    end

    assign Grant_o  = grant_q;
    assign Rvalid_o = tag_q[READ_LATENCY];

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a small SRAM controller model (READ_LATENCY = 2).
`timescale 1ns/1ps
module tb_sram_arbiter;

    localparam int NR = 4;
    localparam int MB = 4;
    localparam int RL = 2;

    logic                 clk = 1'b0;
    logic                 Resetn;
    logic [NR-1:0]        Req_i;
    logic [NR-1:0][17:0]  Addr_i;
    logic [NR-1:0][15:0]  Wdata_i;
    logic [NR-1:0]        We_n_i;
    logic [NR-1:0]        Grant_o;
    logic [15:0]          Rdata_o;
    logic [NR-1:0]        Rvalid_o;
    logic [17:0]          SRAM_address_o;
    logic [15:0]          SRAM_write_data_o;
    logic                 SRAM_we_n_o;
    logic [15:0]          SRAM_read_data_i;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sram_arbiter #(
        .NUM_REQ      (NR),
        .MAX_BURST    (MB),
        .READ_LATENCY (RL)
    ) dut (
        .Clock_50          (clk),
        .Resetn            (Resetn),
        .Req_i             (Req_i),
        .Addr_i            (Addr_i),
        .Wdata_i           (Wdata_i),
        .We_n_i            (We_n_i),
        .Grant_o           (Grant_o),
        .Rdata_o           (Rdata_o),
        .Rvalid_o          (Rvalid_o),
        .SRAM_address_o    (SRAM_address_o),
        .SRAM_write_data_o (SRAM_write_data_o),
        .SRAM_we_n_o       (SRAM_we_n_o),
        .SRAM_read_data_i  (SRAM_read_data_i)
    );

    // SRAM controller model: data for an address issued at edge N is sampled by the DUT at edge N+2.
    logic [15:0] mem [0:255];
    logic [15:0] rd_q;
    logic        mem_clr;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++)
                mem[i] <= (i == 'h34) ? 16'hBEEF : (16'hD000 | 16'(i));
        end else if (!SRAM_we_n_o) begin
            mem[SRAM_address_o[7:0]] <= SRAM_write_data_o;
        end
        rd_q <= mem[SRAM_address_o[7:0]];
    end
    assign SRAM_read_data_i = rd_q;

    typedef struct {
        logic [3:0]  req;
        logic [17:0] addr;
        logic [3:0]  exp_grant;
        logic [3:0]  exp_rvalid;
        logic [15:0] exp_rdata;
        logic [17:0] exp_addr;
        logic        chk_addr;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] r, input logic [17:0] a, input logic [3:0] eg,
                                input logic [3:0] ev, input logic [15:0] ed, input logic [17:0] ea,
                                input logic ca);
        vec_t v;
        v.req = r; v.addr = a; v.exp_grant = eg; v.exp_rvalid = ev;
        v.exp_rdata = ed; v.exp_addr = ea; v.chk_addr = ca;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] r, input logic [17:0] a, input logic wn, input logic [15:0] wd);
        Req_i   = r;
        Addr_i  = {NR{a}};
        We_n_i  = {NR{wn}};
        Wdata_i = {NR{wd}};
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_grant"}, 32'(Grant_o), 32'h0);
        chk({tag, "_rvalid"}, 32'(Rvalid_o), 32'h0);
        chk({tag, "_rdata"}, 32'(Rdata_o), 32'h0);
        chk({tag, "_addr"}, 32'(SRAM_address_o), 32'h0);
        chk({tag, "_wdata"}, 32'(SRAM_write_data_o), 32'h0);
        chk({tag, "_we_n"}, 32'(SRAM_we_n_o), 32'h1);
    endtask

    vec_t        vt [17];
    logic [3:0]  acc;
    logic [3:0]  eg;
    int          ph;

    initial begin
        // Single read by master 2 from 0x01234, then an 8-read burst by master 0.
        vt[0] = mk(4'b0100, 18'h01234, 4'b0100, 4'b0000, 16'h0,    18'h00000, 1'b1);
        vt[1] = mk(4'b0100, 18'h01234, 4'b0100, 4'b0000, 16'h0,    18'h01234, 1'b1);
        vt[2] = mk(4'b0000, 18'h01234, 4'b0000, 4'b0000, 16'h0,    18'h01234, 1'b1);
        vt[3] = mk(4'b0000, 18'h00000, 4'b0000, 4'b0100, 16'hBEEF, 18'h01234, 1'b1);
        vt[4] = mk(4'b0000, 18'h00000, 4'b0000, 4'b0000, 16'h0,    18'h01234, 1'b1);
        vt[5] = mk(4'b0001, 18'h00000, 4'b0001, 4'b0000, 16'h0,    18'h00000, 1'b0);
        for (int b = 1; b <= 11; b++) begin
            logic [3:0]  ev;
            logic [15:0] ed;
            ev = (b >= 3 && b <= 10) ? 4'b0001 : 4'b0000;
            ed = (b >= 3 && b <= 10) ? (16'hD000 + 16'(b - 3)) : 16'h0;
            if (b <= 8)
                vt[5 + b] = mk(4'b0001, 18'(b - 1), 4'b0001, ev, ed, 18'(b - 1), 1'b1);
            else
                vt[5 + b] = mk(4'b0000, 18'h0, 4'b0000, ev, ed, 18'h7, 1'b1);
        end

        Resetn  = 1'b0;
        mem_clr = 1'b1;
        drive(4'b0000, 18'h0, 1'b1, 16'h0);
        repeat (3) step();
        chk_reset_outputs("init_rst");
        Resetn  = 1'b1;
        mem_clr = 1'b0;
        step();
        chk("post_rst_grant", 32'(Grant_o), 32'h0);

        for (int k = 0; k < 17; k++) begin
            drive(vt[k].req, vt[k].addr, 1'b1, 16'h0);
            step();
            chk($sformatf("row%0d_grant", k), 32'(Grant_o), 32'(vt[k].exp_grant));
            chk($sformatf("row%0d_rvalid", k), 32'(Rvalid_o), 32'(vt[k].exp_rvalid));
            chk($sformatf("row%0d_we_n", k), 32'(SRAM_we_n_o), 32'h1);
            if (vt[k].exp_rvalid != 4'b0000)
                chk($sformatf("row%0d_rdata", k), 32'(Rdata_o), 32'(vt[k].exp_rdata));
            if (vt[k].chk_addr)
                chk($sformatf("row%0d_addr", k), 32'(SRAM_address_o), 32'(vt[k].exp_addr));
        end

        // Early release: master 3 drops after 2 accesses while master 1 waits.
        drive(4'b1000, 18'h00040, 1'b1, 16'h0);
        step(); chk("er_grant3", 32'(Grant_o), 32'h8);
        drive(4'b1010, 18'h00041, 1'b1, 16'h0);
        step(); chk("er_own_a", 32'(Grant_o), 32'h8);
        chk("er_addr_a", 32'(SRAM_address_o), 32'h41);
        step(); chk("er_own_b", 32'(Grant_o), 32'h8);
        drive(4'b0010, 18'h00042, 1'b1, 16'h0);
        step(); chk("er_release", 32'(Grant_o), 32'h0);
        chk("er_no_issue", 32'(SRAM_address_o), 32'h41);
        step(); chk("er_grant1", 32'(Grant_o), 32'h2);
        drive(4'b0000, 18'h0, 1'b1, 16'h0);
        repeat (5) step();

        // Burst limit: master 3 owns, master 0 waits -> exactly MAX_BURST accesses then handover.
        drive(4'b1000, 18'h00050, 1'b1, 16'h0);
        step(); chk("mb_grant3", 32'(Grant_o), 32'h8);
        drive(4'b1001, 18'h00050, 1'b1, 16'h0);
        for (int n = 0; n < 3; n++) begin
            step(); chk($sformatf("mb_own%0d", n), 32'(Grant_o), 32'h8);
        end
        step(); chk("mb_release", 32'(Grant_o), 32'h0);
        step(); chk("mb_grant0", 32'(Grant_o), 32'h1);
        drive(4'b0000, 18'h0, 1'b1, 16'h0);
        repeat (5) step();

        // Write 0xA5A5 to the top address, then read it back.
        drive(4'b0100, 18'h3FFFF, 1'b0, 16'hA5A5);
        step(); chk("wr_grant", 32'(Grant_o), 32'h4);
        chk("wr_we_n_pre", 32'(SRAM_we_n_o), 32'h1);
        step(); chk("wr_we_n_low", 32'(SRAM_we_n_o), 32'h0);
        chk("wr_addr", 32'(SRAM_address_o), 32'h3FFFF);
        chk("wr_data", 32'(SRAM_write_data_o), 32'hA5A5);
        drive(4'b0100, 18'h3FFFF, 1'b1, 16'h0);
        step(); chk("rd_we_n", 32'(SRAM_we_n_o), 32'h1);
        chk("rd_addr", 32'(SRAM_address_o), 32'h3FFFF);
        drive(4'b0000, 18'h0, 1'b1, 16'h0);
        step(); chk("wr_no_rvalid", 32'(Rvalid_o), 32'h0);
        chk("wr_we_n_post", 32'(SRAM_we_n_o), 32'h1);
        chk("wr_released", 32'(Grant_o), 32'h0);
        step(); chk("rd_rvalid", 32'(Rvalid_o), 32'h4);
        chk("rd_rdata", 32'(Rdata_o), 32'hA5A5);
        chk("rd_we_n_post", 32'(SRAM_we_n_o), 32'h1);
        repeat (3) step();

        // Reset in the middle of a 5-read burst by master 1.
        drive(4'b0010, 18'h00010, 1'b1, 16'h0);
        step();
        drive(4'b0010, 18'h00011, 1'b1, 16'h0);
        step();
        drive(4'b0010, 18'h00012, 1'b1, 16'h0);
        step();
        chk("mid_grant", 32'(Grant_o), 32'h2);
        #2;
        Resetn = 1'b0;
        drive(4'b0000, 18'h0, 1'b1, 16'h0);
        #1;
        chk_reset_outputs("mid_rst");
        step();
        step();
        Resetn = 1'b1;
        acc = 4'b0000;
        repeat (6) begin
            step();
            acc |= Rvalid_o;
        end
        chk("rst_dropped_reads", 32'(acc), 32'h0);
        chk("rst_idle_grant", 32'(Grant_o), 32'h0);

        // Contention: masters 0 and 3 both held, starting from a freshly reset arbiter.
        drive(4'b1001, 18'h00060, 1'b1, 16'h0);
        for (int n = 1; n <= 15; n++) begin
            step();
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            ph = (n - 1) % 10;
            eg = (ph < 4) ? 4'b0001 : (ph == 4) ? 4'b0000 : (ph < 9) ? 4'b1000 : 4'b0000;
`else
            ph = n;
            eg = 4'b0001;
`endif
            chk($sformatf("cont_n%0d_p%0d", n, ph), 32'(Grant_o), 32'(eg));
        end
        drive(4'b0000, 18'h0, 1'b1, 16'h0);
        repeat (4) step();
        chk("final_idle", 32'(Grant_o), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
